mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter AW, 32, address width in bits.
REQ-002 Parameter DW, 32, data width in bits; byte enables are DW/8 wide.
REQ-003 Parameter STARVE_MAX, 4, maximum consecutive data grants while fetch waits.
REQ-004 Parameter TIMEOUT_CYCLES, 255, cycles in BUSY without m_ack before abort (timeout build only).
REQ-005 Port clk, in, 1, the single clock; all logic samples on its rising edge.
REQ-006 Port rst, in, 1, reset; asynchronous and active-high.
REQ-007 Ports i_req in 1, i_addr in AW, i_gnt out 1, i_rvalid out 1, i_rdata out DW: instruction-fetch read port.
REQ-008 Ports d_req in 1, d_we in 1, d_addr in AW, d_wdata in DW, d_be in DW/8, d_gnt out 1, d_rvalid out 1, d_rdata out DW: load/store port.
REQ-009 Ports m_req out 1, m_we out 1, m_addr out AW, m_wdata out DW, m_be out DW/8, m_ack in 1, m_rdata in DW: shared memory port.
REQ-010 Port err, out, 1, one-cycle pulse on aborted transaction (timeout build only; otherwise tied 0).

Function
REQ-011 The FSM SHALL have states IDLE, BUSY_I, BUSY_D.
REQ-012 In IDLE with any request, the arbiter SHALL grant exactly one requester: a one-cycle i_gnt or d_gnt pulse in that same cycle, capture its address/data/be/we, and enter BUSY_I or BUSY_D at the next edge.
REQ-013 Priority: data wins over fetch unless the starvation counter equals STARVE_MAX and i_req is high, in which case fetch wins.
REQ-014 Starvation counter: increments on each d_gnt while i_req is high, saturates at STARVE_MAX, clears on i_gnt or any cycle i_req is low.
REQ-015 In BUSY, m_req SHALL be 1 and m_we/m_addr/m_wdata/m_be SHALL hold captured values stable until m_ack; fetch transactions drive m_we=0, m_be all-ones.
REQ-016 On m_ack in BUSY, the FSM SHALL return to IDLE; on the next cycle the owner's rvalid pulses for one cycle with rdata = m_rdata registered (0 for writes).
REQ-017 rvalid pulses for writes as well as reads; the non-owner's rvalid stays 0.
REQ-018 A new grant is possible in the cycle after m_ack (one idle bubble per transaction minimum); m_req SHALL be 0 in IDLE.
REQ-019 m_ack in IDLE SHALL be ignored.
REQ-020 Requests dropped before grant are simply not served; request inputs are ignored in BUSY.
REQ-021 Grant to memory-request latency: m_req rises the cycle after gnt.

Reset
REQ-022 rst SHALL asynchronously force IDLE, starvation counter 0, timeout counter 0, and all outputs 0 (gnt, rvalid, rdata, m_*, err).
REQ-023 Reset mid-transaction abandons it with no rvalid; an m_ack arriving after release is ignored per REQ-019.

Configuration
REQ-024 Macro MEM_ARB_TIMEOUT_EN defined: a counter runs in BUSY; after TIMEOUT_CYCLES cycles without m_ack the FSM returns to IDLE, and the next cycle the owner's rvalid pulses with rdata 0 together with err=1.
REQ-025 If m_ack and timeout coincide, m_ack wins (normal completion, err=0).
REQ-026 Macro undefined: no timeout counter, BUSY waits indefinitely, err tied 0.

Structure
REQ-027 Package mem_arb_pkg SHALL hold the state encoding, owner encoding (OWN_I, OWN_D), and default parameter constants.
REQ-028 Sub-module mem_arb_pick SHALL hold the priority/starvation decision (inputs i_req, d_req, counter; outputs grant selection).
REQ-029 RTL SHALL synthesize to NOT/NAND/NOR/AOI/OAI cells plus flip-flops; no memories, no latches.

Verification
REQ-030 Only i_req=1, addr 0x100, m_ack after 3 cycles with m_rdata 0xDEADBEEF -> i_gnt cycle 0, m_req cycles 1-3, i_rvalid=1 with i_rdata 0xDEADBEEF at cycle 4.
REQ-031 i_req and d_req both held, ack latency 1, STARVE_MAX=4 -> grant order D,D,D,D,I,D,D,D,D,I.
REQ-032 d_we=1, d_be=0x3, d_wdata 0x12345678 -> m_we=1, m_be=0x3, m_wdata 0x12345678 stable until ack; d_rvalid=1, d_rdata=0.
REQ-033 rst asserted mid-BUSY_D, then m_ack -> all outputs 0 immediately, no rvalid, FSM in IDLE.
REQ-034 MEM_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, no ack -> m_req drops after 8 BUSY cycles, then d_rvalid=1, err=1, d_rdata=0; repeat with ack on cycle 8 -> err=0, normal data.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared definitions for the two-port memory arbiter:
//   state_e  - arbiter FSM states (IDLE, BUSY_I, BUSY_D)
//   owner_e  - which port owns a grant / transaction (OWN_I, OWN_D)
//   DEF_*    - default parameter values used by mem_arbiter and mem_arb_pick
// -----------------------------------------------------------------------------
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_e;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_e;

    localparam int DEF_AW             = 32;
    localparam int DEF_DW             = 32;
    localparam int DEF_STARVE_MAX     = 4;
    localparam int DEF_TIMEOUT_CYCLES = 255;

endpackage

// File: rtl/mem_arb_pick.sv
// -----------------------------------------------------------------------------
// mem_arb_pick
// Priority decision between the fetch and load/store ports. Data normally
// wins; fetch wins once it has been passed over STARVE_MAX times in a row.
// Ports:
//   i_req, d_req  in   requests from the fetch / load-store ports
//   starve_cnt    in   consecutive data grants while fetch was waiting
//   gnt_valid     out  some port is requesting
//   gnt_owner     out  port that would be granted (valid when gnt_valid)
// -----------------------------------------------------------------------------
module mem_arb_pick
    import mem_arb_pkg::*;
#(
    parameter int STARVE_MAX = DEF_STARVE_MAX,
    parameter int CW         = $clog2(STARVE_MAX + 1)
) (
    input  logic          i_req,
    input  logic          d_req,
    input  logic [CW-1:0] starve_cnt,
    output logic          gnt_valid,
    output owner_e        gnt_owner
);

    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment, otherwise synthesis infers a latch.
    always_comb begin
        gnt_valid = i_req | d_req;
        gnt_owner = OWN_D;
        if (i_req && (!d_req || starve_cnt == CW'(STARVE_MAX))) begin
            gnt_owner = OWN_I;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Arbitrates an instruction-fetch read port and a load/store port onto one
// shared memory port, one transaction at a time.
// Optional build macro: MEM_ARB_TIMEOUT_EN adds a BUSY watchdog that aborts a
// transaction after TIMEOUT_CYCLES cycles without m_ack and pulses err.
// Ports:
//   clk, rst                     clock, async active-high reset
//   i_req/i_addr                 fetch request; i_gnt, i_rvalid, i_rdata back
//   d_req/d_we/d_addr/d_wdata/d_be  load/store request; d_gnt, d_rvalid, d_rdata
//   m_req/m_we/m_addr/m_wdata/m_be  shared memory request; m_ack, m_rdata back
//   err                          one-cycle pulse with rvalid on an aborted transaction
// -----------------------------------------------------------------------------
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW             = DEF_AW,
    parameter int DW             = DEF_DW,
    parameter int STARVE_MAX     = DEF_STARVE_MAX,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic            clk,
    input  logic            rst,
    // fetch port
    input  logic            i_req,
    input  logic [AW-1:0]   i_addr,
    output logic            i_gnt,
    output logic            i_rvalid,
    output logic [DW-1:0]   i_rdata,
    // load/store port
    input  logic            d_req,
    input  logic            d_we,
    input  logic [AW-1:0]   d_addr,
    input  logic [DW-1:0]   d_wdata,
    input  logic [DW/8-1:0] d_be,
    output logic            d_gnt,
    output logic            d_rvalid,
    output logic [DW-1:0]   d_rdata,
    // shared memory port
    output logic            m_req,
    output logic            m_we,
    output logic [AW-1:0]   m_addr,
    output logic [DW-1:0]   m_wdata,
    output logic [DW/8-1:0] m_be,
    input  logic            m_ack,
    input  logic [DW-1:0]   m_rdata,
    output logic            err
);

    localparam int CW = $clog2(STARVE_MAX + 1);

    state_e          state, state_nxt;
    logic [CW-1:0]   starve_cnt;
    logic            pick_valid;
    owner_e          pick_owner;
    logic            busy;
    logic            timeout_hit;
    logic            done;
    logic [DW-1:0]   rsp_data;

    mem_arb_pick #(
        .STARVE_MAX (STARVE_MAX),
        .CW         (CW)
    ) u_pick (
        .i_req      (i_req),
        .d_req      (d_req),
        .starve_cnt (starve_cnt),
        .gnt_valid  (pick_valid),
        .gnt_owner  (pick_owner)
    );

    assign busy  = (state != IDLE);
    assign m_req = busy;
    // Ack always wins over a coinciding timeout.
    assign done  = busy && (m_ack || timeout_hit);
    // Writes and aborted transactions return zero data.
    assign rsp_data = (m_ack && !m_we) ? m_rdata : '0;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_cnt;

    // Counts BUSY cycles already elapsed; the last allowed cycle fires the abort.
    assign timeout_hit = busy && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt <= '0;
            err     <= 1'b0;
        end else begin
            tmo_cnt <= busy ? tmo_cnt + 1'b1 : '0;
            err     <= done && !m_ack;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign err         = 1'b0;
`endif

    // Grants are combinational in IDLE and masked while reset is held so no
    // grant pulse escapes during reset.
    always_comb begin
        state_nxt = state;
        i_gnt     = 1'b0;
        d_gnt     = 1'b0;
        unique case (state)
            IDLE: begin
                if (pick_valid && !rst) begin
                    if (pick_owner == OWN_I) begin
                        i_gnt     = 1'b1;
                        state_nxt = BUSY_I;
                    end else begin
                        d_gnt     = 1'b1;
                        state_nxt = BUSY_D;
                    end
                end
            end
            BUSY_I, BUSY_D: begin
                if (done) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            starve_cnt <= '0;
            m_we       <= 1'b0;
            m_addr     <= '0;
            m_wdata    <= '0;
            m_be       <= '0;
            i_rvalid   <= 1'b0;
            i_rdata    <= '0;
            d_rvalid   <= 1'b0;
            d_rdata    <= '0;
        end else begin
            state    <= state_nxt;
            i_rvalid <= 1'b0;
            d_rvalid <= 1'b0;

            if (!i_req || i_gnt) begin
                starve_cnt <= '0;
            end else if (d_gnt && starve_cnt != CW'(STARVE_MAX)) begin
                starve_cnt <= starve_cnt + 1'b1;
            end

            if (i_gnt) begin
                m_we    <= 1'b0;
                m_addr  <= i_addr;
                m_wdata <= '0;
                m_be    <= '1;
            end else if (d_gnt) begin
                m_we    <= d_we;
                m_addr  <= d_addr;
                m_wdata <= d_wdata;
                m_be    <= d_be;
            end

            if (done) begin
                if (state == BUSY_I) begin
                    i_rvalid <= 1'b1;
                    i_rdata  <= rsp_data;
                end else begin
                    d_rvalid <= 1'b1;
                    d_rdata  <= rsp_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Directed bench for mem_arbiter (AW=DW=32, STARVE_MAX=4, TIMEOUT_CYCLES=8).
// Inputs change 1ns after the rising edge; outputs are sampled on the
// falling edge. Expected values are hand-derived constants.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_gnt, i_rvalid;
    logic [31:0] i_rdata;
    logic        d_req, d_we;
    logic [31:0] d_addr, d_wdata;
    logic [3:0]  d_be;
    logic        d_gnt, d_rvalid;
    logic [31:0] d_rdata;
    logic        m_req, m_we;
    logic [31:0] m_addr, m_wdata;
    logic [3:0]  m_be;
    logic        m_ack;
    logic [31:0] m_rdata;
    logic        err;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_arbiter #(
        .AW             (32),
        .DW             (32),
        .STARVE_MAX     (4),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .i_req    (i_req),
        .i_addr   (i_addr),
        .i_gnt    (i_gnt),
        .i_rvalid (i_rvalid),
        .i_rdata  (i_rdata),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_be     (d_be),
        .d_gnt    (d_gnt),
        .d_rvalid (d_rvalid),
        .d_rdata  (d_rdata),
        .m_req    (m_req),
        .m_we     (m_we),
        .m_addr   (m_addr),
        .m_wdata  (m_wdata),
        .m_be     (m_be),
        .m_ack    (m_ack),
        .m_rdata  (m_rdata),
        .err      (err)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_gnt"},    {i_gnt, d_gnt}, 0);
        check({tag, "_rvalid"}, {i_rvalid, d_rvalid}, 0);
        check({tag, "_rdata"},  {i_rdata, d_rdata}, 0);
        check({tag, "_mctl"},   {m_req, m_we, m_be, err}, 0);
        check({tag, "_maddr"},  {m_addr, m_wdata}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic got_d [10];
    logic prev_d;
    int   ngr;
    int   busy_n;

    initial begin
        rst = 1'b1; i_req = 1'b1; i_addr = 32'h0; d_req = 1'b1; d_we = 1'b0;
        d_addr = 32'h0; d_wdata = 32'h0; d_be = 4'h0; m_ack = 1'b0; m_rdata = 32'h0;

        // ---- reset state, requests held high must not produce grants ----
        smp();
        check_all_zero("reset");
        cyc();
        rst = 1'b0; i_req = 1'b0; d_req = 1'b0;
        smp();
        check("idle_mreq", m_req, 0);

        // ---- single fetch, ack after 3 busy cycles ----
        cyc();
        i_req = 1'b1; i_addr = 32'h100;
        smp();
        check("fetch_c0_gnt", {i_gnt, d_gnt, m_req}, 3'b100);
        cyc();
        i_req = 1'b0;
        smp();
        check("fetch_c1_mreq", m_req, 1);
        check("fetch_c1_maddr", m_addr, 32'h100);
        check("fetch_c1_we_be", {m_we, m_be}, 5'b0_1111);
        check("fetch_c1_gnt", {i_gnt, d_gnt}, 0);
        cyc();
        smp();
        check("fetch_c2_mreq", m_req, 1);
        cyc();
        m_ack = 1'b1; m_rdata = 32'hDEADBEEF;
        smp();
        check("fetch_c3_mreq", {m_req, i_rvalid}, 2'b10);
        cyc();
        m_ack = 1'b0;
        smp();
        check("fetch_c4_mreq", m_req, 0);
        check("fetch_c4_rvalid", {i_rvalid, d_rvalid}, 2'b10);
        check("fetch_c4_rdata", i_rdata, 32'hDEADBEEF);

        // ---- stray ack in IDLE is ignored ----
        cyc();
        m_ack = 1'b1;
        smp();
        check("idle_ack_c0", {i_rvalid, d_rvalid, m_req}, 0);
        cyc();
        m_ack = 1'b0;
        smp();
        check("idle_ack_c1", {i_rvalid, d_rvalid, m_req, i_gnt, d_gnt}, 0);

        // ---- both ports requesting, ack latency 1: D,D,D,D,I,D,D,D,D,I ----
        cyc();
        i_req = 1'b1; d_req = 1'b1; m_ack = 1'b1; i_addr = 32'h40; d_addr = 32'h80;
        ngr = 0; prev_d = 1'b0;
        for (int t = 0; t < 40; t++) begin
            smp();
            if (i_rvalid || d_rvalid)
                check("starve_rvalid_owner", {i_rvalid, d_rvalid}, prev_d ? 2'b01 : 2'b10);
            if (i_gnt || d_gnt) begin
                check("starve_one_gnt", i_gnt & d_gnt, 0);
                got_d[ngr] = d_gnt;
                prev_d     = d_gnt;
                ngr++;
            end
            if (ngr == 10) break;
            cyc();
        end
        check("starve_grant_count", ngr, 10);
        check("starve_order", {got_d[0], got_d[1], got_d[2], got_d[3], got_d[4],
                               got_d[5], got_d[6], got_d[7], got_d[8], got_d[9]},
              10'b11110_11110);
        cyc();
        i_req = 1'b0; d_req = 1'b0;
        cyc();
        m_ack = 1'b0;
        smp();
        check("starve_last_rvalid", {i_rvalid, d_rvalid}, 2'b10);

        // ---- partial write held stable until ack ----
        cyc();
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h200; d_be = 4'h3; d_wdata = 32'h12345678;
        smp();
        check("wr_gnt", {i_gnt, d_gnt}, 2'b01);
        for (int j = 0; j < 3; j++) begin
            cyc();
            d_req = 1'b0; d_we = 1'b0; d_wdata = 32'hFFFFFFFF; d_be = 4'hF;
            m_rdata = 32'hCAFEF00D;
            if (j == 2) m_ack = 1'b1;
            smp();
            check("wr_busy_ctl", {m_req, m_we, m_be}, 6'b11_0011);
            check("wr_busy_data", {m_addr, m_wdata}, {32'h200, 32'h12345678});
        end
        cyc();
        m_ack = 1'b0;
        smp();
        check("wr_rvalid", {i_rvalid, d_rvalid, m_req}, 3'b010);
        check("wr_rdata", d_rdata, 0);

        // ---- reset in the middle of a data read ----
        cyc();
        d_req = 1'b1; d_addr = 32'h300;
        smp();
        check("rst_mid_gnt", d_gnt, 1);
        cyc();
        d_req = 1'b0;
        smp();
        check("rst_mid_busy", {m_req, m_addr}, {1'b1, 32'h300});
        #1 rst = 1'b1;
        #1;
        check_all_zero("rst_async");
        cyc();
        rst = 1'b0; m_ack = 1'b1; m_rdata = 32'h0BADF00D;
        smp();
        check("rst_after_ack_c0", {m_req, i_rvalid, d_rvalid}, 0);
        cyc();
        m_ack = 1'b0;
        smp();
        check("rst_after_ack_c1", {m_req, i_rvalid, d_rvalid, err}, 0);
        check("rst_after_rdata", {i_rdata, d_rdata}, 0);
        cyc();
        i_req = 1'b1; i_addr = 32'h500;
        smp();
        check("rst_regrant", {i_gnt, d_gnt}, 2'b10);
        cyc();
        i_req = 1'b0; m_ack = 1'b1;
        cyc();
        m_ack = 1'b0;
        smp();
        check("rst_regrant_rsp", {i_rvalid, i_rdata}, {1'b1, 32'h0BADF00D});

        // ---- read with no ack: timeout build aborts after 8 busy cycles ----
        cyc();
        d_req = 1'b1; d_addr = 32'h600; m_rdata = 32'hA5A5A5A5;
        smp();
        check("tmo_gnt", d_gnt, 1);
        busy_n = 0;
        for (int c = 1; c <= 8; c++) begin
            cyc();
            d_req = 1'b0;
            smp();
            busy_n += int'(m_req);
            check("tmo_no_err_busy", {err, d_rvalid}, 0);
        end
        check("tmo_busy_cycles", busy_n, 8);
        cyc();
        smp();
`ifdef MEM_ARB_TIMEOUT_EN
        check("tmo_abort", {m_req, d_rvalid, i_rvalid, err}, 4'b0101);
        check("tmo_rdata", d_rdata, 0);
        cyc();
        smp();
        check("tmo_err_pulse", {err, d_rvalid}, 0);
`else
        check("notmo_still_busy", {m_req, d_rvalid, err}, 3'b100);
        for (int c = 0; c < 20; c++) begin
            cyc();
            smp();
            check("notmo_wait", {m_req, d_rvalid, err}, 3'b100);
        end
        cyc();
        m_ack = 1'b1;
        cyc();
        m_ack = 1'b0;
        smp();
        check("notmo_done", {m_req, d_rvalid, err}, 3'b010);
        check("notmo_rdata", d_rdata, 32'hA5A5A5A5);
`endif

        // ---- ack on the 8th busy cycle: normal completion, no err ----
        cyc();
        d_req = 1'b1; d_addr = 32'h700; m_rdata = 32'h5A5A1234;
        smp();
        check("ack8_gnt", d_gnt, 1);
        for (int c = 1; c <= 8; c++) begin
            cyc();
            d_req = 1'b0;
            if (c == 8) m_ack = 1'b1;
            smp();
            check("ack8_busy", {m_req, err}, 2'b10);
        end
        cyc();
        m_ack = 1'b0;
        smp();
        check("ack8_done", {m_req, d_rvalid, err}, 3'b010);
        check("ack8_rdata", d_rdata, 32'h5A5A1234);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
